// File: rtl/ecc_host_ctrl.sv
// ecc_host_ctrl: host register front-end for an ECC scalar-multiply core.
// Loads operands, launches the core, waits with timeout, streams the result.
`ifndef MAX_BITS
`define MAX_BITS 256
`endif

module ecc_host_ctrl #(
  parameter int WIDTH   = `MAX_BITS,
  parameter int TIMEOUT = 1048576
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [2:0]       i_wr_sel,
  input  logic [31:0]      i_wr_data,
  input  logic             i_go,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_inf,
  output logic             o_wr_err,
  output logic             o_rd_valid,
  output logic [31:0]      o_rd_data,
  input  logic             i_rd_ready,
  output logic             o_core_start,
  output logic [1:0]       o_core_mode,
  output logic [WIDTH-1:0] o_core_x,
  output logic [WIDTH-1:0] o_core_y,
  output logic [WIDTH-1:0] o_core_p,
  output logic [WIDTH-1:0] o_core_a,
  output logic [WIDTH-1:0] o_core_b,
  output logic [WIDTH-1:0] o_core_n,
  input  logic             i_core_finished,
  input  logic [WIDTH-1:0] i_core_x,
  input  logic [WIDTH-1:0] i_core_y
);

  localparam int NW = 2 * WIDTH / 32;
  localparam int RW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    READ
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [RW-1:0]      rd_idx;
  logic [2*WIDTH-1:0] res;
  logic               idle;

  assign idle      = (state == IDLE);
  assign o_rd_data = res[2*WIDTH-1 -: 32];

  function automatic logic [WIDTH-1:0] shift_in(
    input logic [WIDTH-1:0] r,
    input logic [31:0]      d
  );
    return (r << 32) | {{(WIDTH-32){1'b0}}, d};
  endfunction

  // Operand loading: only while idle, so operands hold steady when busy
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_core_x    <= '0;
      o_core_y    <= '0;
      o_core_p    <= '0;
      o_core_a    <= '0;
      o_core_b    <= '0;
      o_core_n    <= '0;
      o_core_mode <= '0;
    end else if (idle && i_wr_en) begin
      case (i_wr_sel)
        3'd0: o_core_x <= shift_in(o_core_x, i_wr_data);
        3'd1: o_core_y <= shift_in(o_core_y, i_wr_data);
        3'd2: o_core_p <= shift_in(o_core_p, i_wr_data);
        3'd3: o_core_a <= shift_in(o_core_a, i_wr_data);
        3'd4: o_core_b <= shift_in(o_core_b, i_wr_data);
        3'd5: o_core_n <= shift_in(o_core_n, i_wr_data);
        3'd6: o_core_mode <= i_wr_data[1:0];
        default: ;
      endcase
    end
  end

  // Control FSM: launch, bounded wait, result capture and word stream
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_idx       <= '0;
      res          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_timeout    <= 1'b0;
      o_inf        <= 1'b0;
      o_wr_err     <= 1'b0;
      o_rd_valid   <= 1'b0;
      o_core_start <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_core_start <= 1'b0;
      if (!idle && (i_wr_en || i_go))
        o_wr_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (i_go) begin
            state        <= LAUNCH;
            o_busy       <= 1'b1;
            o_core_start <= 1'b1;
            o_wr_err     <= 1'b0;
            o_timeout    <= 1'b0;
            o_inf        <= 1'b0;
          end
        end
        LAUNCH: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (i_core_finished) begin
            res        <= {i_core_x, i_core_y};
            o_inf      <= (&i_core_x) && (&i_core_y);
            cnt        <= '0;
            rd_idx     <= '0;
            o_rd_valid <= 1'b1;
            state      <= READ;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          if (i_rd_ready) begin
            res    <= res << 32;
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == RW'(NW - 1)) begin
              o_rd_valid <= 1'b0;
              o_done     <= 1'b1;
              o_busy     <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_host_ctrl.sv
// tb_ecc_host_ctrl: randomized bench for ecc_host_ctrl.
// Reference model tracks operands and expected result stream.
module tb_ecc_host_ctrl;

  localparam int W  = 256;
  localparam int TO = 16;
  localparam int NW = 2 * W / 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [2:0]    i_wr_sel = '0;
  logic [31:0]   i_wr_data = '0;
  logic          i_go = 1'b0;
  logic          o_busy, o_done, o_timeout, o_inf, o_wr_err;
  logic          o_rd_valid;
  logic [31:0]   o_rd_data;
  logic          i_rd_ready = 1'b0;
  logic          o_core_start;
  logic [1:0]    o_core_mode;
  logic [W-1:0]  o_core_x, o_core_y, o_core_p;
  logic [W-1:0]  o_core_a, o_core_b, o_core_n;
  logic          i_core_finished = 1'b0;
  logic [W-1:0]  i_core_x = '0;
  logic [W-1:0]  i_core_y = '0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_op[6];
  logic [1:0]   m_mode;

  ecc_host_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_data(i_wr_data),
    .i_go(i_go),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout),
    .o_inf(o_inf), .o_wr_err(o_wr_err),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_rd_ready(i_rd_ready),
    .o_core_start(o_core_start), .o_core_mode(o_core_mode),
    .o_core_x(o_core_x), .o_core_y(o_core_y), .o_core_p(o_core_p),
    .o_core_a(o_core_a), .o_core_b(o_core_b), .o_core_n(o_core_n),
    .i_core_finished(i_core_finished),
    .i_core_x(i_core_x), .i_core_y(i_core_y)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] dut_op(input int i);
    case (i)
      0: return o_core_x;
      1: return o_core_y;
      2: return o_core_p;
      3: return o_core_a;
      4: return o_core_b;
      default: return o_core_n;
    endcase
  endfunction

  function automatic logic all_zero();
    return {o_busy, o_done, o_timeout, o_inf, o_wr_err, o_rd_valid,
            o_rd_data, o_core_start, o_core_mode, o_core_x, o_core_y,
            o_core_p, o_core_a, o_core_b, o_core_n} === '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_op[i] = '0;
    m_mode = '0;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_sel = sel; i_wr_data = d;
    tick();
    i_wr_en = 1'b0;
    if (sel < 3'd6) m_op[sel] = (m_op[sel] << 32) | W'(d);
    else if (sel == 3'd6) m_mode = d[1:0];
  endtask

  task automatic cmp_ops(input string tag);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dut_op(i) !== m_op[i]) begin
        errors++;
        $display("FAIL %s op%0d got %h want %h", tag, i, dut_op(i), m_op[i]);
      end
    end
    checks++;
    if (o_core_mode !== m_mode) begin
      errors++;
      $display("FAIL %s mode got %0d want %0d", tag, o_core_mode, m_mode);
    end
  endtask

  task automatic do_go();
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_core_start !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL launch busy=%b start=%b done=%b want 1 1 0",
               o_busy, o_core_start, o_done);
    end
    tick();
    checks++;
    if (o_busy !== 1'b1 || o_core_start !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry busy=%b start=%b want 1 0",
               o_busy, o_core_start);
    end
    cmp_ops("ops_held");
  endtask

  task automatic run_wait(input int lat, input logic [W-1:0] x,
                          input logic [W-1:0] y);
    logic inf_exp;
    inf_exp = (x == {W{1'b1}}) && (y == {W{1'b1}});
    for (int i = 0; i < TO; i++) begin
      if (i == lat) begin
        i_core_finished = 1'b1; i_core_x = x; i_core_y = y;
      end else begin
        i_core_x = rnd_w(); i_core_y = rnd_w();
      end
      tick();
      i_core_finished = 1'b0;
      if (i == lat) begin
        checks++;
        if (o_rd_valid !== 1'b1 || o_timeout !== 1'b0 ||
            o_busy !== 1'b1 || o_done !== 1'b0 || o_inf !== inf_exp) begin
          errors++;
          $display("FAIL finish vld=%b to=%b busy=%b done=%b inf=%b want 1 0 1 0 %b",
                   o_rd_valid, o_timeout, o_busy, o_done, o_inf, inf_exp);
        end
        return;
      end
      checks++;
      if (i == TO - 1) begin
        if (o_timeout !== 1'b1 || o_done !== 1'b1 ||
            o_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
          errors++;
          $display("FAIL timeout to=%b done=%b busy=%b vld=%b want 1 1 0 0",
                   o_timeout, o_done, o_busy, o_rd_valid);
        end
      end else if (o_done !== 1'b0 || o_busy !== 1'b1 ||
                   o_rd_valid !== 1'b0 || o_timeout !== 1'b0) begin
        errors++;
        $display("FAIL waiting cyc%0d done=%b busy=%b vld=%b to=%b want 0 1 0 0",
                 i, o_done, o_busy, o_rd_valid, o_timeout);
      end
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_rd_valid !== 1'b0 || o_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after done=%b vld=%b to=%b want 0 0 1",
               o_done, o_rd_valid, o_timeout);
    end
  endtask

  task automatic read_stream(input logic [W-1:0] x, input logic [W-1:0] y,
                             input int hold0);
    logic [31:0] exp_q[$];
    int idx;
    int cyc;
    logic r;
    for (int k = 0; k < W / 32; k++)
      exp_q.push_back(32'(x >> (32 * (W / 32 - 1 - k))));
    for (int k = 0; k < W / 32; k++)
      exp_q.push_back(32'(y >> (32 * (W / 32 - 1 - k))));
    idx = 0;
    cyc = 0;
    while (idx < NW && cyc < 400) begin
      r = (idx == 0 && cyc < hold0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      i_rd_ready = r;
      checks++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== exp_q[idx] || o_done !== 1'b0) begin
        errors++;
        $display("FAIL word%0d vld=%b data=%h done=%b want 1 %h 0",
                 idx, o_rd_valid, o_rd_data, o_done, exp_q[idx]);
      end
      tick();
      cyc++;
      if (r) idx++;
    end
    i_rd_ready = 1'b0;
    checks++;
    if (idx != NW || o_done !== 1'b1 || o_rd_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_end words=%0d done=%b vld=%b busy=%b want %0d 1 0 0",
               idx, o_done, o_rd_valid, o_busy, NW);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b vld=%b want 0 0", o_done, o_rd_valid);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_zero busy=%b done=%b vld=%b start=%b want all 0",
               o_busy, o_done, o_rd_valid, o_core_start);
    end
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL reset_release busy=%b done=%b want all 0", o_busy, o_done);
    end
  endtask

  task automatic test_write();
    logic [W-1:0] exp_x;
    exp_x = '0;
    for (int k = 1; k <= 8; k++) begin
      wr(3'd0, 32'(k));
      exp_x[32 * (8 - k) +: 32] = 32'(k);
    end
    checks++;
    if (o_core_x !== exp_x || o_core_y !== '0) begin
      errors++;
      $display("FAIL x_load x=%h y=%h want x=%h y=0", o_core_x, o_core_y, exp_x);
    end
    for (int s = 1; s < 6; s++)
      for (int k = 0; k < 8; k++) wr(3'(s), $urandom);
    wr(3'd6, $urandom);
    wr(3'd7, $urandom);
    cmp_ops("rand_load");
    checks++;
    if (o_wr_err !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL sel7 err=%b busy=%b want 0 0", o_wr_err, o_busy);
    end
  endtask

  task automatic test_read_hold();
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = W'(5);
    y = W'(7);
    do_go();
    run_wait(2, x, y);
    read_stream(x, y, 3);
    checks++;
    if (o_inf !== 1'b0 || o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL read_flags inf=%b to=%b want 0 0", o_inf, o_timeout);
    end
  endtask

  task automatic test_timeout();
    do_go();
    run_wait(TO, rnd_w(), rnd_w());
    do_go();
    checks++;
    if (o_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear to=%b want 0", o_timeout);
    end
    begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = rnd_w();
      y = rnd_w();
      run_wait(TO - 1, x, y);
      read_stream(x, y, 0);
    end
  endtask

  task automatic test_inf();
    do_go();
    run_wait(4, {W{1'b1}}, {W{1'b1}});
    read_stream({W{1'b1}}, {W{1'b1}}, 1);
    checks++;
    if (o_inf !== 1'b1) begin
      errors++;
      $display("FAIL inf_flag inf=%b want 1", o_inf);
    end
  endtask

  task automatic test_busy_err();
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = rnd_w();
    y = rnd_w();
    do_go();
    i_wr_en = 1'b1; i_wr_sel = 3'd5; i_wr_data = $urandom;
    tick();
    i_wr_en = 1'b0;
    checks++;
    if (o_core_n !== m_op[5] || o_wr_err !== 1'b1) begin
      errors++;
      $display("FAIL busy_write n=%h err=%b want %h 1", o_core_n, o_wr_err, m_op[5]);
    end
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    checks++;
    if (o_core_start !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_go start=%b busy=%b want 0 1", o_core_start, o_busy);
    end
    run_wait(3, x, y);
    read_stream(x, y, 0);
    checks++;
    if (o_wr_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky err=%b want 1", o_wr_err);
    end
    wr(3'd5, $urandom);
    cmp_ops("n_reload");
    do_go();
    checks++;
    if (o_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear err=%b want 0", o_wr_err);
    end
    run_wait(0, y, x);
    read_stream(y, x, 0);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x;
    logic [W-1:0] y;
    do_go();
    tick();
    tick();
    i_rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL rst_wait busy=%b done=%b start=%b want all 0",
               o_busy, o_done, o_core_start);
    end
    tick();
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL rst_hold busy=%b done=%b want all 0", o_busy, o_done);
    end
    i_rst = 1'b1;
    tick();
    i_core_finished = 1'b1;
    tick();
    i_core_finished = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_rd_valid !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_finish busy=%b vld=%b done=%b want 0 0 0",
               o_busy, o_rd_valid, o_done);
    end
    wr(3'd2, $urandom);
    cmp_ops("post_rst");
    x = rnd_w();
    y = rnd_w();
    do_go();
    run_wait(1, x, y);
    i_rd_ready = 1'b1;
    tick();
    tick();
    tick();
    i_rd_ready = 1'b0;
    i_rst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (!all_zero()) begin
      errors++;
      $display("FAIL rst_read vld=%b busy=%b data=%h want all 0",
               o_rd_valid, o_busy, o_rd_data);
    end
    tick();
    i_rst = 1'b1;
    tick();
    x = rnd_w();
    y = rnd_w();
    do_go();
    run_wait(5, x, y);
    read_stream(x, y, 2);
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    int lat;
    for (int it = 0; it < 6; it++) begin
      for (int s = 0; s < 6; s++)
        if ($urandom_range(0, 1) == 1)
          for (int k = 0; k < $urandom_range(1, 8); k++) wr(3'(s), $urandom);
      wr(3'd6, $urandom);
      cmp_ops("rnd_ops");
      do_go();
      lat = $urandom_range(0, TO + 1);
      x = (it == 2) ? {W{1'b1}} : rnd_w();
      y = (it == 2) ? {W{1'b1}} : rnd_w();
      run_wait(lat, x, y);
      if (lat < TO) read_stream(x, y, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_timeout();
    test_inf();
    test_busy_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_host_ctrl.md
ECC_HOST_CTRL -- requirements
Module: ecc_host_ctrl

Interface
REQ-001 Parameter WIDTH, default `MAX_BITS; operand width in bits, SHALL be a multiple of 32.
REQ-002 Parameter TIMEOUT, default 1048576; maximum cycles spent in WAIT before abort.
REQ-003 Reset i_rst, asynchronous, active-low; clock i_clk.
REQ-004 i_clk  in  1  clock, all state on rising edge.
REQ-005 i_rst  in  1  async active-low reset.
REQ-006 i_wr_en  in  1  host operand word write strobe.
REQ-007 i_wr_sel  in  3  target: 0=X, 1=Y, 2=P, 3=A, 4=B, 5=N, 6=MODE, 7=reserved.
REQ-008 i_wr_data  in  32  write word.
REQ-009 i_go  in  1  launch scalar multiplication.
REQ-010 o_busy  out  1  high whenever state != IDLE.
REQ-011 o_done  out  1  one-cycle pulse at end of every launched operation.
REQ-012 o_timeout  out  1  last operation aborted on timeout; o_inf out 1: last result is point at infinity; o_wr_err out 1: sticky, write or go rejected while busy.
REQ-013 o_rd_valid  out  1 / o_rd_data  out  32 / i_rd_ready  in  1  result word stream, valid/ready handshake.
REQ-014 o_core_start  out  1  start pulse to scalar-multiply core.
REQ-015 o_core_mode  out  2; o_core_x, o_core_y, o_core_p, o_core_a, o_core_b, o_core_n  out  WIDTH each; registered operands to core.
REQ-016 i_core_finished  in  1; i_core_x, i_core_y  in  WIDTH; core completion and result.

Function
REQ-017 States SHALL be IDLE, LAUNCH, WAIT, READ.
REQ-018 In IDLE, i_wr_en with sel 0-5 SHALL shift the operand: reg <= {reg[WIDTH-33:0], i_wr_data}; WIDTH/32 writes load MSW first.
REQ-019 sel 6 SHALL load o_core_mode <= i_wr_data[1:0]; sel 7 SHALL be ignored without error.
REQ-020 Writes or i_go outside IDLE SHALL be ignored and SHALL set o_wr_err; o_wr_err clears on next accepted i_go.
REQ-021 Operand registers SHALL retain values across operations (reload of N alone permitted).
REQ-022 i_go in IDLE -> LAUNCH; in LAUNCH o_core_start = 1 for exactly one cycle; next state WAIT; o_timeout, o_inf cleared on accepted go.
REQ-023 WAIT: cycle counter increments each cycle from 0; i_core_finished = 1 -> capture i_core_x/y into result registers, o_inf <= (x all-ones AND y all-ones), counter cleared, -> READ.
REQ-024 WAIT: counter == TIMEOUT-1 without finished -> o_timeout <= 1, o_done pulse, -> IDLE, no READ phase.
REQ-025 finished and timeout in same cycle: finished SHALL win.
REQ-026 i_core_finished outside WAIT SHALL be ignored.
REQ-027 READ: 2*WIDTH/32 words, X MSW..LSW then Y MSW..LSW; o_rd_valid high throughout; o_rd_data stable while o_rd_valid & !i_rd_ready.
REQ-028 Word advances only on o_rd_valid & i_rd_ready; acceptance of final word -> o_rd_valid 0, o_done pulse, -> IDLE in same edge.
REQ-029 All outputs SHALL be registered; core operand outputs SHALL not change while o_busy.

Reset
REQ-030 i_rst low SHALL asynchronously force IDLE, all operand/result registers, o_core_mode, counters and every output to 0.
REQ-031 Reset mid-WAIT or mid-READ SHALL abandon the operation without o_done; first go after release SHALL behave as from power-up.

Verification (WIDTH=256, TIMEOUT=16 for bench)
REQ-032 Write sel 0 words 1..8 -> o_core_x = 0x00000001_00000002_..._00000008; o_core_y unchanged 0.
REQ-033 i_go in IDLE -> o_busy 1 next edge, o_core_start high exactly one cycle, then WAIT.
REQ-034 core finished x=5, y=7, i_rd_ready low 3 cycles on word 0 -> word 0 held; stream = 7x0,5,7x0,7; o_done one pulse after 16th word; o_inf 0.
REQ-035 No finished for 16 WAIT cycles -> o_timeout 1, o_done pulse, IDLE, o_rd_valid never asserted; finished on cycle 16 instead -> READ, o_timeout 0.
REQ-036 finished with x=y=all-ones -> o_inf 1, 16 words of 0xFFFFFFFF streamed.
REQ-037 Write sel 5 during WAIT -> o_core_n unchanged, o_wr_err 1; assert i_rst in WAIT -> all outputs 0, no o_done; subsequent go completes normally.
